// File: rtl/mcp320x_scan_spi.sv
// rtl/mcp320x_scan_spi.sv - SPI master for MCP320x-style ADCs with on-demand and round-robin scan
//
// Purpose: issues a 5-bit command (start, SGL, D2..D0) and captures a DATA_W-bit
// result, tagging it with its channel. SCLK is a registered pin driven from a
// divider tick; it is never used as a clock.
//
// Ports:
//   clk, rst_n          system clock, synchronous active-low reset
//   start, ch_sel, sgl  one-shot conversion request (sampled only in IDLE)
//   scan_en             continuous single-ended round-robin scan
//   data_out, data_ch   last result and its channel
//   new_data            one-cycle pulse when data_out/data_ch update
//   busy                high whenever a frame (including the CS gap) is in progress
//   data_in_pin         ADC DOUT
//   cmd_pin, clk_pin    ADC DIN and SCLK (idle low)
//   cs_pin_n            chip select, active low
module mcp320x_scan_spi #(
    parameter int CLK_DIV     = 2,
    parameter int DATA_W      = 12,
    parameter int NUM_CH      = 8,
    parameter int CS_HIGH_CYC = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        ch_sel,
    input  logic              sgl,
    input  logic              scan_en,
    output logic [DATA_W-1:0] data_out,
    output logic [2:0]        data_ch,
    output logic              new_data,
    output logic              busy,
    input  logic              data_in_pin,
    output logic              cmd_pin,
    output logic              clk_pin,
    output logic              cs_pin_n
);
    localparam int DIV_W  = $clog2(CLK_DIV + 1);
    localparam int HALVES = 2 * (7 + DATA_W);
    localparam int HALF_W = $clog2(HALVES);
    localparam int GAP_W  = $clog2(CS_HIGH_CYC + 1);

    localparam logic [2:0]        CH_MASK    = 3'(NUM_CH - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [HALF_W-1:0] HALF_LAST  = HALF_W'(HALVES - 1);
    // Low half-period that ends with rising edge 8, the first data edge.
    localparam logic [HALF_W-1:0] HALF_DATA0 = HALF_W'(14);
    localparam logic [GAP_W-1:0]  GAP_LAST   = GAP_W'(CS_HIGH_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        CS_HOLD,
        GAP
    } state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [HALF_W-1:0]   half_q, half_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [3:0]          cmd_sr_q, cmd_sr_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic [2:0]          ch_q, ch_d;
    logic [2:0]          ptr_q, ptr_d;
    logic                scan_q, scan_d;
    logic                clk_pin_q, clk_pin_d;
    logic                cs_n_q, cs_n_d;
    logic                cmd_q, cmd_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic [2:0]          dch_q, dch_d;
    logic                nd_q, nd_d;
    logic                busy_q, busy_d;
    logic                tick;
    logic                req_sgl;

    always_comb begin
        state_d   = state_q;
        half_d    = half_q;
        gap_d     = gap_q;
        cmd_sr_d  = cmd_sr_q;
        shreg_d   = shreg_q;
        ch_d      = ch_q;
        ptr_d     = ptr_q;
        scan_d    = scan_q;
        clk_pin_d = clk_pin_q;
        cs_n_d    = cs_n_q;
        cmd_d     = cmd_q;
        dout_d    = dout_q;
        dch_d     = dch_q;
        nd_d      = 1'b0;
        busy_d    = busy_q;
        req_sgl   = 1'b0;
        tick      = (div_q == DIV_LAST);
        div_d     = tick ? '0 : div_q + 1'b1;

        case (state_q)
            IDLE: begin
                // Held at zero so every frame starts with a fresh divider phase.
                div_d = '0;
                if (start || scan_en) begin
                    if (start) begin
                        ch_d    = ch_sel & CH_MASK;
                        req_sgl = sgl;
                        scan_d  = 1'b0;
                    end else begin
                        ch_d    = ptr_q;
                        req_sgl = 1'b1;
                        scan_d  = 1'b1;
                    end
                    cmd_sr_d  = {req_sgl, ch_d};
                    cmd_d     = 1'b1;
                    clk_pin_d = 1'b0;
                    cs_n_d    = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = CS_SETUP;
                end
            end
            CS_SETUP: begin
                if (tick) begin
                    half_d  = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (tick) begin
                    half_d = half_q + 1'b1;
                    if (!half_q[0]) begin
                        // Low half ends: SCLK rises, sample DOUT on data edges.
                        clk_pin_d = 1'b1;
                        if (half_q >= HALF_DATA0) begin
                            shreg_d = (shreg_q << 1) | DATA_W'(data_in_pin);
                        end
                    end else begin
                        // High half ends: SCLK falls, present next command bit
                        // (zeros once D0 has gone out).
                        clk_pin_d = 1'b0;
                        cmd_d     = cmd_sr_q[3];
                        cmd_sr_d  = {cmd_sr_q[2:0], 1'b0};
                        if (half_q == HALF_LAST) begin
                            state_d = CS_HOLD;
                        end
                    end
                end
            end
            CS_HOLD: begin
                if (tick) begin
                    cs_n_d  = 1'b1;
                    nd_d    = 1'b1;
                    dout_d  = shreg_q;
                    dch_d   = ch_q;
                    gap_d   = '0;
                    state_d = GAP;
                    if (scan_q) begin
                        ptr_d = (ptr_q + 3'd1) & CH_MASK;
                    end
                end
            end
            GAP: begin
                // CS stays high for CS_HIGH_CYC cycles starting at the new_data cycle.
                if (gap_q == GAP_LAST) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                cs_n_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            div_q     <= '0;
            half_q    <= '0;
            gap_q     <= '0;
            cmd_sr_q  <= '0;
            shreg_q   <= '0;
            ch_q      <= '0;
            ptr_q     <= '0;
            scan_q    <= 1'b0;
            clk_pin_q <= 1'b0;
            cs_n_q    <= 1'b1;
            cmd_q     <= 1'b0;
            dout_q    <= '0;
            dch_q     <= '0;
            nd_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            half_q    <= half_d;
            gap_q     <= gap_d;
            cmd_sr_q  <= cmd_sr_d;
            shreg_q   <= shreg_d;
            ch_q      <= ch_d;
            ptr_q     <= ptr_d;
            scan_q    <= scan_d;
            clk_pin_q <= clk_pin_d;
            cs_n_q    <= cs_n_d;
            cmd_q     <= cmd_d;
            dout_q    <= dout_d;
            dch_q     <= dch_d;
            nd_q      <= nd_d;
            busy_q    <= busy_d;
        end
    end

    assign data_out = dout_q;
    assign data_ch  = dch_q;
    assign new_data = nd_q;
    assign busy     = busy_q;
    assign cmd_pin  = cmd_q;
    assign clk_pin  = clk_pin_q;
    assign cs_pin_n = cs_n_q;

endmodule

// File: doc/mcp320x_scan_spi.md
# mcp320x_scan_spi

Parametrised SPI master for MCP320x-family multi-channel ADCs (MCP3202/3204/3208 style framing). It issues a start/SGL/channel command, captures a DATA_W-bit result, and tags the result with its channel. Conversions run either on demand (`start`) or in a continuous round-robin scan. Everything runs in the single system clock domain: SCLK is a registered output gated by a divider tick and is never used as a clock. It sits between the ADC pins and the sample-processing logic.

## Interface
- `CLK_DIV`, default 2: clk cycles per SCLK half-period; must be ≥1.
- `DATA_W`, default 12: result bits captured per frame.
- `NUM_CH`, default 8: channel count; one of 1, 2, 4, 8.
- `CS_HIGH_CYC`, default 8: minimum clk cycles `cs_pin_n` stays high between frames; must be ≥1.
- `clk` input 1: system clock. The block has one clock.
- `rst_n` input 1: reset. Synchronous, active-low, sampled on the `clk` rising edge.
- `start` input 1: request one conversion; sampled only in IDLE.
- `ch_sel` input 3: channel for `start`. Only the low log2(NUM_CH) bits are used; upper bits are treated as 0.
- `sgl` input 1: 1 selects single-ended, 0 selects differential; latched with `start`.
- `scan_en` input 1: continuous single-ended round-robin scan.
- `data_out` output DATA_W: last result, MSB-first capture.
- `data_ch` output 3: channel of `data_out`.
- `new_data` output 1: one-cycle pulse; `data_out` and `data_ch` are valid from this cycle until the next pulse.
- `busy` output 1: high whenever the state is not IDLE.
- `data_in_pin` input 1: ADC DOUT.
- `cmd_pin` output 1: ADC DIN.
- `clk_pin` output 1: SCLK, idle low (SPI mode 0,0).
- `cs_pin_n` output 1: chip select, active low.

## Operation
- Reset values (while `rst_n`=0): `cs_pin_n`=1, `clk_pin`=0, `cmd_pin`=0, `data_out`=0, `data_ch`=0, `new_data`=0, `busy`=0. Also: scan pointer=0, divider=0, state IDLE.
- States and transitions:
  - IDLE → CS_SETUP → SHIFT → CS_HOLD → GAP → IDLE.
- IDLE, request priority:
  - If `start`=1: latch `ch_sel` and `sgl`. The scan pointer is unchanged.
  - Else if `scan_en`=1: use the scan pointer with sgl=1.
  - Else stay in IDLE.
- Command word, 5 bits, MSB first: 1 (start bit), SGL, D2, D1, D0.
- Frame is 7+DATA_W SCLK cycles:
  - Rising edges 1–5 carry the command bits.
  - Rising edges 6–7 are the sample and null periods; `data_in_pin` is ignored.
  - Rising edges 8…7+DATA_W capture data MSB first. `data_in_pin` is sampled in the clk cycle that drives `clk_pin` 0→1.
- `cmd_pin` drive timing:
  - Takes the start bit on CS_SETUP entry.
  - Changes only on the clk cycle that drives `clk_pin` 1→0.
  - Is 0 after D0 is sent.
- End of frame:
  - CS_HOLD: `clk_pin` low for CLK_DIV cycles.
  - Then `cs_pin_n`→1, and `data_out`/`data_ch` update in the same cycle as the `new_data` pulse.
- Scan pointer: increments after each scan frame and wraps NUM_CH−1→0.
- `scan_en` deasserted mid-frame: the frame completes and is reported, then the block returns to IDLE.
- `start` while busy: ignored, not queued.
- Reset mid-frame: all outputs return to reset values on the next edge. No `new_data` is generated and no partial result is exposed.

## Timing
- Let D=CLK_DIV. Each SCLK half-period is exactly D clk cycles, and `clk_pin` toggles only on divider ticks.
- Divider restarts at 0 on CS_SETUP entry, so frame timing is independent of the previous frame.
- `start` accepted at edge t0:
  - `cs_pin_n`=0 and `busy`=1 from t0+1.
  - CS_SETUP lasts D cycles.
  - SHIFT lasts 2D·(7+DATA_W) cycles.
  - CS_HOLD lasts D cycles.
  - `new_data` is high in cycle t0+1+2D·(8+DATA_W). For D=2, DATA_W=12 this is t0+81.
- GAP:
  - `cs_pin_n` is held high for CS_HIGH_CYC cycles, counted from the `new_data` cycle.
  - `busy` falls after GAP, and the next request can be accepted on the following edge.
- Back-to-back scan period: 2D·(8+DATA_W)+CS_HIGH_CYC+1 cycles per sample.

## Test plan
- Single-ended request: reset, then `start` with `ch_sel`=5, `sgl`=1; the ADC model returns 0xA5C.
  - `cmd_pin` on rising edges 1–5 is 1,1,1,0,1.
  - 19 SCLK rising edges per frame.
  - `data_out`=0xA5C, `data_ch`=5.
  - `new_data` is a single pulse at t0+81 (D=2).
- Differential request: `sgl`=0, `ch_sel`=2.
  - Command bits are 1,0,0,1,0.
  - Model value 0x001 → `data_out`=0x001.
- Scan with NUM_CH=4, `scan_en` held high:
  - `data_ch` sequence is 0,1,2,3,0,1.
  - `cs_pin_n` high ≥CS_HIGH_CYC cycles between frames.
  - `start`/`ch_sel`=6 masks to channel 2.
- Overlapping and simultaneous requests:
  - `start` pulsed mid-frame → ignored, exactly one `new_data`.
  - `start` and `scan_en` both high in IDLE → the `start` channel is used and the scan pointer is unchanged.
- Reset mid-frame: `rst_n`=0 at SCLK edge 10.
  - Next cycle: `cs_pin_n`=1, `clk_pin`=0, `busy`=0, `data_out`=0.
  - No `new_data` pulse.
  - A new `start` after release completes normally.
- Minimum divider: CLK_DIV=1, DATA_W=10.
  - Each SCLK half-period is 1 cycle and there are 17 SCLK edges.
  - Latency 1+2·18 = 37 cycles; model 0x3FF → `data_out`=0x3FF.
